// File: rtl/acc_ram_sequencer.sv
// acc_ram_sequencer: read-modify-write sequencer for a 4-entry accumulator RAM.
// Partial results are added into (or overwrite) a RAM entry at one per cycle.
// A tagged last input triggers a drain of all entries to a downstream port.
// Each entry is zeroed as it is drained.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds valid and its payload stable until that edge.
// in_ready does not depend on in_valid. out_valid does not depend on out_ready.
//
// RAM timing: ram_q is the registered read of the address driven in the
// previous cycle, with write bypass. A write lands on the address driven in
// the previous cycle. The read address is therefore driven combinationally
// in the accept cycle, and the add happens in the following cycle.
module acc_ram_sequencer #(
  parameter int DATA_W = 80,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_first,
  input  logic              in_last,
  output logic [ADDR_W-1:0] ram_rdaddress,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ENTRY = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACC,
    S_FLUSH,
    S_DRAIN_RD,
    S_DRAIN_CAP,
    S_DRAIN_WAIT
  } state_t;

  state_t              state;
  logic [ADDR_W:0]     clr_cnt;   // CLEAR cycle index; the top bit marks the final cycle
  logic [ADDR_W-1:0]   k;         // drain entry index
  logic [ADDR_W-1:0]   rdaddr_q;  // last driven read address, held when idle
  logic                s2_valid;
  logic [DATA_W-1:0]   s2_data;
  logic                s2_first;
  logic                accept;
  logic [DATA_W-1:0]   acc_sum;

  // Accept decode, stage-2 sum, and RAM port drive per state.
  always_comb begin
    accept        = in_valid && (state == S_ACC);
    acc_sum       = s2_first ? s2_data : (ram_q + s2_data);
    in_ready      = (state == S_ACC);
    busy          = (state != S_ACC);
    ram_rdaddress = rdaddr_q;
    ram_wren      = 1'b0;
    ram_data      = '0;
    case (state)
      S_CLEAR: begin
        if (!clr_cnt[ADDR_W]) ram_rdaddress = clr_cnt[ADDR_W-1:0];
        ram_wren = (clr_cnt != '0);
      end
      S_ACC: begin
        if (accept) ram_rdaddress = in_addr;
        ram_wren = s2_valid;
        if (s2_valid) ram_data = acc_sum;
      end
      S_FLUSH: begin
        ram_wren = s2_valid;
        if (s2_valid) ram_data = acc_sum;
      end
      S_DRAIN_RD:  ram_rdaddress = k;
      S_DRAIN_CAP: ram_wren = 1'b1;
      default: ;
    endcase
  end

  // Sequencer state, stage-2 pipeline register, and registered drain outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      k         <= '0;
      rdaddr_q  <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_first  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      rdaddr_q <= ram_rdaddress;
      s2_valid <= accept;
      if (accept) begin
        s2_data  <= in_data;
        s2_first <= in_first;
      end
      case (state)
        S_CLEAR: begin
          if (clr_cnt[ADDR_W]) state <= S_ACC;
          else                 clr_cnt <= clr_cnt + CNT_ONE;
        end
        S_ACC: begin
          if (accept && in_last) state <= S_FLUSH;
        end
        S_FLUSH: begin
          k     <= '0;
          state <= S_DRAIN_RD;
        end
        S_DRAIN_RD: state <= S_DRAIN_CAP;
        S_DRAIN_CAP: begin
          out_data  <= ram_q;
          out_addr  <= k;
          out_valid <= 1'b1;
          out_last  <= (k == LAST_ENTRY);
          state     <= S_DRAIN_WAIT;
        end
        S_DRAIN_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (k == LAST_ENTRY) begin
              state <= S_ACC;
            end else begin
              k     <= k + ADDR_ONE;
              state <= S_DRAIN_RD;
            end
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ram_sequencer.sv
// tb_acc_ram_sequencer: bench for acc_ram_sequencer with a behavioural RAM
// (registered read, write bypass, write to the previous cycle's address) and
// an entry-array reference model feeding an expected-drain queue.
module tb_acc_ram_sequencer;
  localparam int DATA_W = 80;
  localparam int ADDR_W = 2;

  logic              clk, rst_n;
  logic              in_valid, in_ready, in_first, in_last;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] ram_rdaddress;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_data, ram_q;
  logic              out_valid, out_ready, out_last, busy;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  acc_ram_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
    .in_first(in_first), .in_last(in_last),
    .ram_rdaddress(ram_rdaddress), .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_last(out_last), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // ---------------- RAM model ----------------
  logic [DATA_W-1:0] mem [4];
  logic [ADDR_W-1:0] ram_waddr;
  logic              scramble;

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 4; i++) mem[i] <= rand80();
    end else if (ram_wren) begin
      mem[ram_waddr] <= ram_data;
    end
    ram_q     <= (ram_wren && ram_waddr == ram_rdaddress) ? ram_data : mem[ram_rdaddress];
    ram_waddr <= ram_rdaddress;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] model_mem [4];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_d;
  int n_checks, n_pass;

  // drain capture
  logic [DATA_W-1:0] got_data [4];
  logic [ADDR_W-1:0] got_addr [4];
  logic              got_last [4];
  int                got_cyc  [4];
  int                got_n, first_valid_cyc, stall_writes;
  bit                stable_ok, ready_during, ready_after;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                      input bit f, input bit l);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      in_valid = 1'b0;
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!in_ready) $display("FAIL send_ready: in_ready=%b after %0d cycles, want 1", in_ready, guard);
    else n_pass++;
    in_valid = 1'b1; in_data = d; in_addr = a; in_first = f; in_last = l;
    @(posedge clk);
    if (f) model_mem[a] = d;
    else   model_mem[a] = model_mem[a] + d;
    if (l) begin
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(model_mem[i]);
        model_mem[i] = '0;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Collects one drain; in_valid is held high with junk to show it is ignored.
  task automatic collect(input int stall_idx, input int stall_len, input bit rand_ready);
    int cyc, stalled;
    bit holding;
    logic [DATA_W-1:0] hold_d;
    logic [ADDR_W-1:0] hold_a;
    cyc = 0; stalled = 0; holding = 0; hold_d = '0; hold_a = '0;
    got_n = 0; first_valid_cyc = -1; stable_ok = 1; stall_writes = 0; ready_during = 0;
    for (int i = 0; i < 4; i++) begin
      got_data[i] = 'x; got_addr[i] = 'x; got_last[i] = 1'bx; got_cyc[i] = -1;
    end
    while (got_n < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      in_valid = 1'b1; in_data = rand80(); in_addr = 2'($urandom);
      in_first = 1'($urandom); in_last = 1'($urandom);
      if (in_ready) ready_during = 1;
      out_ready = 1'b0;
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (holding && (out_data !== hold_d || out_addr !== hold_a)) stable_ok = 0;
        holding = 1; hold_d = out_data; hold_a = out_addr;
        if (got_n == stall_idx && stalled < stall_len) begin
          stalled++;
        end else if (rand_ready && $urandom_range(0, 2) == 0) begin
          stalled = stalled;
        end else begin
          out_ready = 1'b1;
          got_data[got_n] = out_data; got_addr[got_n] = out_addr;
          got_last[got_n] = out_last; got_cyc[got_n] = cyc;
          got_n++;
          holding = 0;
          if (got_n == 4) in_valid = 1'b0;
        end
        if (!out_ready && ram_wren) stall_writes++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    ready_after = in_ready;
  endtask

  task automatic wait_clear(output int cyc, output int writes);
    cyc = 0; writes = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ram_wren) writes++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cyc, writes;
    rst_n = 1'b0; scramble = 1'b1;
    repeat (2) @(negedge clk);
    scramble = 1'b0;
    n_checks++;
    if ({in_ready, ram_wren, out_valid, out_last, busy} !== 5'b00001)
      $display("FAIL reset_ctrl: rdy/wren/ov/ol/busy=%b, want 00001", {in_ready, ram_wren, out_valid, out_last, busy});
    else n_pass++;
    n_checks++;
    if (ram_rdaddress !== '0 || ram_data !== '0)
      $display("FAIL reset_ram: rdaddr=%0d data=%h, want 0 0", ram_rdaddress, ram_data);
    else n_pass++;
    n_checks++;
    if (out_data !== '0 || out_addr !== '0)
      $display("FAIL reset_out: out_data=%h out_addr=%0d, want 0 0", out_data, out_addr);
    else n_pass++;
    rst_n = 1'b1;
    wait_clear(cyc, writes);
    n_checks++;
    if (cyc !== 5 || writes !== 4)
      $display("FAIL clear_timing: ready after %0d cycles with %0d writes, want 5 and 4", cyc, writes);
    else n_pass++;
    n_checks++;
    if (mem[0] !== '0 || mem[1] !== '0 || mem[2] !== '0 || mem[3] !== '0)
      $display("FAIL clear_mem: %h %h %h %h, want all 0", mem[0], mem[1], mem[2], mem[3]);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_clear_drain();
    send('0, 2'd0, 1'b0, 1'b1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (got_n != 4) $display("FAIL clear_drain_count: got %0d words, want 4", got_n);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL clear_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
    n_checks++;
    if (first_valid_cyc !== 4) $display("FAIL drain_latency: first out_valid at t+%0d, want t+4", first_valid_cyc);
    else n_pass++;
    n_checks++;
    if (got_cyc[3] - got_cyc[0] !== 9) $display("FAIL drain_rate: words 0..3 span %0d cycles, want 9", got_cyc[3] - got_cyc[0]);
    else n_pass++;
    n_checks++;
    if (ready_during !== 0 || ready_after !== 1)
      $display("FAIL drain_ready: during=%b after=%b, want 0 1", ready_during, ready_after);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    send(80'd5, 2'd0, 1'b1, 1'b0);
    send(80'd7, 2'd0, 1'b0, 1'b0);
    send(80'd3, 2'd1, 1'b1, 1'b1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (got_data[0] !== 80'd12 || got_data[1] !== 80'd3)
      $display("FAIL accum_sums: e0=%0d e1=%0d, want 12 3", got_data[0], got_data[1]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL accum_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    send(80'hFFFF_FFFF_FFFF_FFFF_FFFF, 2'd2, 1'b1, 1'b0);
    send(80'd1, 2'd2, 1'b0, 1'b1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (got_data[2] !== '0) $display("FAIL wrap_e2: got %h, want 0", got_data[2]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL wrap_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    send(80'd11, 2'd1, 1'b1, 1'b0);
    send(80'd4, 2'd0, 1'b1, 1'b1);
    collect(1, 5, 1'b0);
    n_checks++;
    if (stable_ok !== 1 || stall_writes !== 0)
      $display("FAIL stall_hold: stable=%b ram writes=%0d, want 1 0", stable_ok, stall_writes);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL stall_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_no_first();
    send(80'd9, 2'd3, 1'b0, 1'b1);
    collect(-1, 0, 1'b0);
    n_checks++;
    if (got_data[3] !== 80'd9) $display("FAIL nofirst_e3: got %0d, want 9", got_data[3]);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL nofirst_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) idle();
        send(rand80(), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), (j == n - 1));
      end
      collect(-1, 0, 1'b1);
      for (int i = 0; i < 4; i++) begin
        exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        n_checks++;
        if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
          $display("FAIL rand%0d_word%0d: got %h/%0d/%b, want %h/%0d/%b", t, i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int guard, cyc, writes;
    guard = 0;
    send(80'd21, 2'd1, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    while (!out_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL midrst_reach_wait: out_valid=%b, want 1", out_valid);
    else n_pass++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, ram_wren, out_valid, out_last, busy} !== 5'b00001)
      $display("FAIL midrst_ctrl: rdy/wren/ov/ol/busy=%b, want 00001", {in_ready, ram_wren, out_valid, out_last, busy});
    else n_pass++;
    n_checks++;
    if (out_data !== '0 || out_addr !== '0 || ram_rdaddress !== '0)
      $display("FAIL midrst_out: out_data=%h out_addr=%0d rdaddr=%0d, want 0 0 0", out_data, out_addr, ram_rdaddress);
    else n_pass++;
    scramble = 1'b1;
    @(negedge clk);
    scramble = 1'b0;
    rst_n = 1'b1;
    wait_clear(cyc, writes);
    n_checks++;
    if (cyc !== 5 || writes !== 4)
      $display("FAIL midrst_clear: ready after %0d cycles with %0d writes, want 5 and 4", cyc, writes);
    else n_pass++;
    model_clear();
    send(80'd6, 2'd2, 1'b0, 1'b1);
    collect(-1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_d = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      n_checks++;
      if (got_data[i] !== exp_d || got_addr[i] !== ADDR_W'(i) || got_last[i] !== (i == 3))
        $display("FAIL midrst_word%0d: got %h/%0d/%b, want %h/%0d/%b", i, got_data[i], got_addr[i], got_last[i], exp_d, i, (i == 3));
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; scramble = 1'b0;
    in_valid = 1'b0; in_data = '0; in_addr = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    model_clear();
    test_reset();
    test_clear_drain();
    test_accumulate();
    test_wrap();
    test_stall();
    test_no_first();
    test_random();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/acc_ram_sequencer.md
# acc_ram_sequencer

Read-modify-write sequencer that drives the 4-entry × 80-bit accumulator RAM.
- Accepts a stream of 80-bit partial results tagged with an entry index.
- For each one, reads the entry, adds the partial result, and writes the sum back.
- At the end of a tile, drains all four entries to a downstream port with a valid/ready handshake, zeroing each entry as it goes.
- Sits between the multiplier datapath and the result writer.

## Interface
Parameters:
- DATA_W, 80, accumulator word width
- ADDR_W, 2, entry index width (DEPTH = 4, fixed)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  partial result present
- in_ready  out  1  sequencer accepts input this cycle
- in_data  in  DATA_W  partial result
- in_addr  in  ADDR_W  target entry
- in_first  in  1  overwrite the entry with in_data instead of adding
- in_last  in  1  final partial result of the tile; triggers drain
- ram_rdaddress  out  ADDR_W  RAM read address
- ram_wren  out  1  RAM write enable (the RAM writes to the address driven in the previous cycle)
- ram_data  out  DATA_W  RAM write data
- ram_q  in  DATA_W  RAM read data, registered, one cycle after ram_rdaddress, with write bypass
- out_valid  out  1  drained word valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  drained accumulator value
- out_addr  out  ADDR_W  entry index of out_data
- out_last  out  1  high with entry 3
- busy  out  1  high in any state except ACC

## Operation
- States:
  - CLEAR: entered on reset; zeroes the RAM.
  - ACC: accumulating; in_ready = 1.
  - FLUSH: one cycle, completes the final write.
  - DRAIN_RD: issues the read of entry k.
  - DRAIN_CAP: captures the entry and clears it.
  - DRAIN_WAIT: holds the output until accepted.
- Reset values:
  - state CLEAR, counter k = 0.
  - in_ready, ram_wren, out_valid, out_last, s2_valid = 0.
  - ram_rdaddress, ram_data, out_data, out_addr = 0.
  - busy = 1.
- CLEAR (5 cycles, c = 0..4):
  - ram_rdaddress = c for c ≤ 3.
  - ram_wren = 1 and ram_data = 0 for c ≥ 1; each write lands on entry c−1.
  - After c = 4 → ACC.
- ACC, stage 1: on in_valid & in_ready:
  - ram_rdaddress = in_addr.
  - Register s2_valid = 1, s2_data = in_data, s2_first = in_first.
  - If in_last, next state is FLUSH.
- ACC, stage 2 (the cycle after acceptance):
  - ram_wren = s2_valid.
  - ram_data = s2_first ? s2_data : (ram_q + s2_data) mod 2^80 (unsigned wrap, carry discarded).
- Back-to-back inputs to the same entry are legal at full rate; the RAM bypass supplies the in-flight sum on ram_q.
- When no input is accepted, ram_rdaddress holds its previous value.
- FLUSH: in_ready = 0; stage 2 of the last input writes; → DRAIN_RD with k = 0.
- DRAIN_RD: ram_rdaddress = k, ram_wren = 0.
- DRAIN_CAP:
  - out_data ← ram_q, out_addr ← k.
  - ram_wren = 1, ram_data = 0 (clears entry k).
- DRAIN_WAIT:
  - out_valid = 1; out_last = (k == 3).
  - On out_ready: if k == 3 → ACC, otherwise k ← k+1 → DRAIN_RD.
- in_ready = 1 only in ACC. in_valid outside ACC is ignored.
- Reset asserted mid-operation aborts any drain or accumulation and re-runs CLEAR. RAM contents are not trusted across reset.

## Timing
- Accept at cycle t → RAM write at the edge ending t+1.
- Accumulate throughput: 1 input per cycle.
- in_last accepted at t:
  - in_ready falls at t+1.
  - DRAIN_RD at t+2.
  - First out_valid at t+4.
- Drain rate with out_ready held high: one word per 3 cycles; 4 words in 12 cycles.
- out_data, out_addr and out_last are stable while out_valid & !out_ready.
- ram_wren is never asserted in two consecutive cycles except during CLEAR and stage-2 accumulate.

## Test plan
- Reset release → 5 CLEAR cycles write 0 to entries 0..3, then in_ready = 1; a drain immediately afterwards returns four zeros.
- Inputs 5→e0 (first), 7→e0, 3→e1 (first, last) on consecutive cycles → drain outputs e0 = 12, e1 = 3, e2 = 0, e3 = 0; out_last only on e3.
- 80'hFFFF_FFFF_FFFF_FFFF_FFFF→e2 (first), then 1→e2 (last) → e2 drains as 0 (wrap).
- out_ready held low for 5 cycles during the e1 word → out_data/out_addr unchanged, no extra RAM write, e1 still delivered once.
- After a drain, 9→e3 without in_first (last) → drains 9 (entry was cleared).
- rst_n pulsed low in DRAIN_WAIT → outputs go to reset values asynchronously, CLEAR re-runs, in_ready returns after 5 cycles.
